fft_stage_sequencer: RTL
========================

// Module: fft_stage_sequencer
// PURPOSE
//  Sequences the radix-2 DIT FFT datapath: ping-pong RAM0/RAM1, twiddle ROM, butterfly.
//  Issues one butterfly per clock across all N_2 stages; read/write addresses, write enables,
//  read-select and twiddle addresses come from a stage/index counter pair.
//  Sits beside the butterfly and RAMs inside the fft top level.
//  Data is preloaded into RAM0 in bit-reversed order before start.
// PARAMETERS
//  width  16  complex half-width of datapath words (not used internally; kept for instantiation symmetry)
//  N_2    5   log2(N) points; N = 2**N_2, N/2 butterflies per stage, N_2 stages
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  start       in   1      begin transform; sampled only in IDLE or DONE
//  busy        out  1      high in PRIME and RUN
//  done        out  1      level, high in DONE until next accepted start or reset
//  rdsel       out  1      0: butterfly reads RAM0, 1: reads RAM1
//  we0, we1    out  1      RAM write enables (write result to the non-source RAM)
//  adr0a/adr0b out  N_2    RAM0 port a/b address
//  adr1a/adr1b out  N_2    RAM1 port a/b address (same values as adr0a/adr0b)
//  twiddleadr  out  N_2-1  twiddle ROM address (ROM has 1-cycle registered read)
//  result_sel  out  1      RAM holding final result: constant = N_2 odd (1 for N_2=5)
// BEHAVIOUR
//  States: IDLE -start-> PRIME -> RUN (N_2*N/2 cycles) -> DONE -start-> PRIME. Reset -> IDLE from any state.
//  Counters s (0..N_2-1), i (0..N/2-1), registered; cleared on reset and on PRIME entry.
//  Address map for (s,i): span=1<<s, grp=i>>s, pos=i&(span-1);
//   adrA=(grp<<(s+1))|pos, adrB=adrA+span, tw(s,i)=pos<<(N_2-1-s). All fields N_2 bits, no overflow.
//  RUN cycle for (s,i): adrXa=adrA, adrXb=adrB (both RAMs); rdsel=s[0]; we0=s[0]; we1=~s[0].
//  RAM write is posedge, read is asynchronous: stage s+1 reads stage s results next cycle; no bubble.
//  twiddleadr is one butterfly ahead: in PRIME = tw(0,0); in RUN (s,i) = tw of next (s,i);
//   in last RUN cycle and all other states = 0. ROM output then aligns with the RUN cycle.
//  Counter advance in RUN: i++; at i=N/2-1: i=0, s++; at (N_2-1, N/2-1): go to DONE.
//  Outside RUN: we0=we1=0, rdsel=0, all addresses 0. busy/done/we reset to 0.
//  Latency: start sampled at edge E0 -> PRIME cycle 1 -> RUN cycles 2..1+N_2*N/2 -> done=1 at cycle 2+N_2*N/2 (82 for N_2=5).
//  start ignored while busy. start in DONE: done drops next cycle, restarts with PRIME.
//  Reset mid-RUN: next cycle IDLE, we0=we1=0, done=0; RAM contents are undefined for the partial transform.
//  Simultaneous reset and start: reset wins.
// STRUCTURE
//  fft_pkg: state enum (IDLE, PRIME, RUN, DONE); functions bf_adr_a/bf_adr_b/bf_twiddle(s,i,N_2).
//  One sub-module: fft_bf_addr (combinational (s,i) -> adrA, adrB, tw), instantiated twice:
//   current (s,i) for RAM addresses, next (s,i) for twiddleadr.
//  Top: FSM + counters + output muxing, all outputs decoded from registered state.
// TESTING (N_2=5)
//  1 reset held 3 cycles -> busy=done=we0=we1=rdsel=0, all adr=0, twiddleadr=0.
//  2 start 1-cycle pulse -> PRIME twiddleadr=0; RUN cycle 1: adr 0/1, we1=1, rdsel=0; done=1 at cycle 82, stays 1.
//  3 stage boundary -> s0 i15: adr 30/31 tw 0; next cycle s1 i0: adr 0/2, rdsel=1, we0=1; s1 i1: adr 1/3, tw 8.
//  4 mid/last checks -> s2 i5: adr 9/13, tw 4; s4 i15: adr 15/31, tw 15, we1=1; result_sel=1.
//  5 start held high through whole run -> single transform, 80 RUN cycles, then immediate restart from DONE.
//  6 reset asserted during s2 -> next cycle IDLE, we=0, done=0; new start -> full 80-cycle run, done at cycle 82.
//  Also: with RAM/ROM/butterfly models, impulse at x[0] -> all 32 bins equal; compare against a golden FFT model.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and butterfly address arithmetic for the radix-2 DIT FFT sequencer.
// Address helpers are plain integer functions so both RTL and elaboration code can use them.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  // Width of the stage counter for a given log2(N).
  function automatic int stage_w(input int n2);
    return (n2 > 1) ? $clog2(n2) : 1;
  endfunction

  function automatic int bf_adr_a(input int s, input int i, input int n2);
    int span;
    int grp;
    int pos;
    span = 1 << s;
    grp  = i >> s;
    pos  = i & (span - 1);
    return ((grp << (s + 1)) | pos) & ((1 << n2) - 1);
  endfunction

  function automatic int bf_adr_b(input int s, input int i, input int n2);
    return (bf_adr_a(s, i, n2) + (1 << s)) & ((1 << n2) - 1);
  endfunction

  // Stages past the last one map to twiddle 0 so a wrapped look-ahead stays harmless.
  function automatic int bf_twiddle(input int s, input int i, input int n2);
    int span;
    int pos;
    if (s >= n2) return 0;
    span = 1 << s;
    pos  = i & (span - 1);
    return (pos << (n2 - 1 - s)) & ((1 << (n2 - 1)) - 1);
  endfunction

endpackage

// File: rtl/fft_bf_addr.sv
// Combinational (stage, index) -> butterfly RAM addresses and twiddle ROM address.
module fft_bf_addr
  import fft_pkg::*;
#(
  parameter int N_2 = 5,
  parameter int S_W = 3
) (
  input  logic [S_W-1:0] s,
  input  logic [N_2-2:0] i,
  output logic [N_2-1:0] adr_a,
  output logic [N_2-1:0] adr_b,
  output logic [N_2-2:0] tw
);

  assign adr_a = N_2'(bf_adr_a(int'(s), int'(i), N_2));
  assign adr_b = N_2'(bf_adr_b(int'(s), int'(i), N_2));
  assign tw    = (N_2 - 1)'(bf_twiddle(int'(s), int'(i), N_2));

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/index sequencer for the in-place ping-pong radix-2 DIT FFT: one butterfly per clock,
// RAM addresses for the current butterfly, twiddle address one butterfly ahead.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rdsel,
  output logic           we0,
  output logic           we1,
  output logic [N_2-1:0] adr0a,
  output logic [N_2-1:0] adr0b,
  output logic [N_2-1:0] adr1a,
  output logic [N_2-1:0] adr1b,
  output logic [N_2-2:0] twiddleadr,
  output logic           result_sel
);

  localparam int             S_W    = stage_w(N_2);
  localparam logic [S_W-1:0] S_LAST = S_W'(N_2 - 1);
  localparam logic [N_2-2:0] I_LAST = '1;

  if (N_2 < 2 || width < 1) begin : g_param_chk
    $error("fft_stage_sequencer: needs N_2 >= 2 and width >= 1");
  end

  fft_state_e     state;
  logic [S_W-1:0] s_cnt;
  logic [N_2-2:0] i_cnt;
  logic [S_W-1:0] s_nxt;
  logic [N_2-2:0] i_nxt;
  logic           last_bf;

  logic [N_2-1:0] cur_adr_a;
  logic [N_2-1:0] cur_adr_b;
  logic [N_2-2:0] cur_tw;
  logic [N_2-1:0] nxt_adr_a;
  logic [N_2-1:0] nxt_adr_b;
  logic [N_2-2:0] nxt_tw;
  logic           unused_nxt_adr;

  assign last_bf = (s_cnt == S_LAST) && (i_cnt == I_LAST);
  assign i_nxt   = i_cnt + 1'b1;
  assign s_nxt   = (i_cnt == I_LAST) ? s_cnt + 1'b1 : s_cnt;

  fft_bf_addr #(.N_2(N_2), .S_W(S_W)) u_cur_addr (
    .s     (s_cnt),
    .i     (i_cnt),
    .adr_a (cur_adr_a),
    .adr_b (cur_adr_b),
    .tw    (cur_tw)
  );

  fft_bf_addr #(.N_2(N_2), .S_W(S_W)) u_nxt_addr (
    .s     (s_nxt),
    .i     (i_nxt),
    .adr_a (nxt_adr_a),
    .adr_b (nxt_adr_b),
    .tw    (nxt_tw)
  );

  // The look-ahead instance only supplies the twiddle prefetch.
  assign unused_nxt_adr = ^{nxt_adr_a, nxt_adr_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_cnt <= '0;
      i_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= PRIME;
            s_cnt <= '0;
            i_cnt <= '0;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          if (last_bf) begin
            state <= DONE;
            s_cnt <= '0;
            i_cnt <= '0;
          end else begin
            s_cnt <= s_nxt;
            i_cnt <= i_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rdsel      = 1'b0;
    we0        = 1'b0;
    we1        = 1'b0;
    adr0a      = '0;
    adr0b      = '0;
    twiddleadr = '0;
    case (state)
      // Counters sit at (0,0) in PRIME, so the current instance yields tw(0,0).
      PRIME: begin
        busy       = 1'b1;
        twiddleadr = cur_tw;
      end
      RUN: begin
        busy       = 1'b1;
        rdsel      = s_cnt[0];
        we0        = s_cnt[0];
        we1        = ~s_cnt[0];
        adr0a      = cur_adr_a;
        adr0b      = cur_adr_b;
        twiddleadr = last_bf ? '0 : nxt_tw;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign adr1a      = adr0a;
  assign adr1b      = adr0b;
  assign result_sel = (N_2 % 2) == 1;

endmodule
